ram_loader: RTL

//  Initiator for the single-port RAM interface (addr/en/we/din/dout): bulk-loads a

---
 rtl/ram_loader_pkg.sv | 16 +
 rtl/ram_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types for the RAM loader: controller states and command opcodes.
package ram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_DUMP = 1'b1
  } op_t;

endpackage

// File: rtl/ram_loader.sv
// RAM loader: bulk-writes a word stream into a RAM region (LOAD) or reads a
// region back out as a stream (DUMP), one command at a time, over a
// single-port RAM interface with combinational read data.
// Optional: define RAM_LOADER_CHKSUM_EN to add chksum_o, the XOR of every word
// written (LOAD) or handed out on the dump stream (DUMP) by the last command.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter  int DEPTH      = 1024,
  parameter  int WORD_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_base_i,
  input  logic [ADDR_WIDTH-1:0] cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  rdata_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
`ifdef RAM_LOADER_CHKSUM_EN
  output logic [WORD_WIDTH-1:0] chksum_o,
`endif
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [WORD_WIDTH-1:0] ram_din_o,
  input  logic [WORD_WIDTH-1:0] ram_dout_i
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic                  err_q, err_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
`ifdef RAM_LOADER_CHKSUM_EN
  logic [WORD_WIDTH-1:0] chk_q, chk_d;
`endif

  // One extra bit on the sum so base+len cannot overflow before the compare.
  logic [ADDR_WIDTH:0] end_sum;
  logic                range_err;
  assign end_sum   = {1'b0, cmd_base_i} + {1'b0, cmd_len_i};
  assign range_err = (end_sum > DEPTH_W);

  // Next-state, RAM strobes and stream control for the active command.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    cur_d         = cur_q;
    rem_d         = rem_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    rvalid_d      = rvalid_q;
    rlast_d       = rlast_q;
    ram_en_o      = 1'b0;
    ram_we_o      = 1'b0;
    ram_din_o     = '0;
    wdata_ready_o = 1'b0;
`ifdef RAM_LOADER_CHKSUM_EN
    chk_d         = chk_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          cur_d = cmd_base_i;
          rem_d = cmd_len_i;
          err_d = range_err;
`ifdef RAM_LOADER_CHKSUM_EN
          chk_d = '0;
`endif
          // Out-of-range or empty commands finish without touching the RAM.
          if (range_err || cmd_len_i == '0) state_d = DONE;
          else if (op_t'(cmd_op_i) == OP_DUMP) state_d = DUMP;
          else state_d = LOAD;
        end
      end
      LOAD: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          ram_en_o  = 1'b1;
          ram_we_o  = 1'b1;
          ram_din_o = wdata_i;
          cur_d     = cur_q + ONE;
          rem_d     = rem_q - ONE;
`ifdef RAM_LOADER_CHKSUM_EN
          chk_d     = chk_q ^ wdata_i;
`endif
          if (rem_q == ONE) state_d = DONE;
        end
      end
      DUMP: begin
        // Output beat consumed: drop valid unless a new read refills it below.
        if (rvalid_q && rdata_ready_i) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
`ifdef RAM_LOADER_CHKSUM_EN
          chk_d    = chk_q ^ rdata_q;
`endif
          if (rlast_q) state_d = DONE;
        end
        // Read the next word whenever the output register is free this cycle.
        if (rem_q != '0 && (!rvalid_q || rdata_ready_i)) begin
          ram_en_o = 1'b1;
          rdata_d  = ram_dout_i;
          rvalid_d = 1'b1;
          rlast_d  = (rem_q == ONE);
          cur_d    = cur_q + ONE;
          rem_d    = rem_q - ONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
`ifdef RAM_LOADER_CHKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      cur_q    <= cur_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
`ifdef RAM_LOADER_CHKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign err_o         = done_o & err_q;
  assign rdata_valid_o = rvalid_q;
  assign rdata_o       = rdata_q;
  assign rdata_last_o  = rlast_q;
  assign ram_addr_o    = cur_q;
`ifdef RAM_LOADER_CHKSUM_EN
  assign chksum_o      = chk_q;
`endif

endmodule
